keypad_scanner: RTL and testbench
=================================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL provide parameter SCAN_DIV, default 25000, meaning clock cycles each column is driven (1 ms at 25 MHz); legal range 2..65535.
REQ-002 SHALL provide parameter DEBOUNCE_FRAMES, default 8, meaning consecutive identical scan frames required before the output changes; legal range 1..15.
REQ-003 SHALL have port CLOCK_25  input  1  system clock; one clock, all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port rows  input  4  keypad row lines, active-low, externally pulled up, asynchronous to CLOCK_25.
REQ-006 SHALL have port cols  output  4  keypad column drive, active-low, exactly one bit low at any time.
REQ-007 SHALL have port key_code  output  4  debounced key code (see REQ-014), 4'd0 when key_valid=0.
REQ-008 SHALL have port key_valid  output  1  high while exactly one key is stably pressed.
REQ-009 SHALL have port key_pressed  output  1  one-cycle pulse on each new debounced key.
REQ-010 SHALL have port multi_key  output  1  high while a stable frame shows two or more keys.

Function
REQ-011 SHALL pass rows through a two-flop synchronizer before any use; sampled values are the synchronizer output.
REQ-012 SHALL scan columns 0,1,2,3 cyclically, driving column c low (cols = ~(4'b0001<<c)) for SCAN_DIV cycles; frame length = 4*SCAN_DIV cycles.
REQ-013 SHALL sample synchronized rows on the last cycle of each column period into snapshot bits [4*c+r] (1 = pressed, i.e. row low), then advance to the next column on the following cycle, wrapping 3 -> 0.
REQ-014 SHALL map (row r, col c) to codes: r0: 1,2,3,10; r1: 4,5,6,11; r2: 7,8,9,12; r3: 14,0,15,13 (columns c0..c3); up = 4'd2, down = 4'd8 for paddle control.
REQ-015 SHALL, on the cycle after column 3 is sampled (frame end), classify the snapshot as NONE (0 bits set), SINGLE(code) (1 bit), or MULTI (>=2 bits).
REQ-016 SHALL compare each classification with the previous frame's; equal -> stable counter increments, saturating at DEBOUNCE_FRAMES; different -> counter loads 1 and the new classification is stored.
REQ-017 SHALL update outputs on the frame-end cycle in which the counter reaches DEBOUNCE_FRAMES: NONE -> valid 0, code 0, multi 0; SINGLE -> valid 1, code, multi 0; MULTI -> valid 0, code 0, multi 1.
REQ-018 SHALL hold outputs unchanged at all other times, including while the counter remains saturated.
REQ-019 SHALL assert key_pressed for exactly one cycle, coincident with an update per REQ-017 that results in SINGLE with either key_valid previously 0 or a different code; MULTI or NONE never pulses.
REQ-020 SHALL keep a held key from re-pulsing; release (stable NONE) followed by a new press SHALL pulse again.
REQ-021 SHALL treat a glitch shorter than DEBOUNCE_FRAMES frames as ignored: outputs keep their prior stable value.
REQ-022 SHALL size the column-period counter to ceil(log2(SCAN_DIV)) bits and the frame counter to 4 bits; no counter shall wrap except the column index.

Reset
REQ-023 SHALL, while reset=1 at a clock edge, set cols=4'b1110, column index 0, period counter 0, snapshot 0, previous classification NONE, stable counter 0, key_code 0, key_valid 0, key_pressed 0, multi_key 0.
REQ-024 SHALL, on reset asserted mid-frame, discard the partial frame; scanning restarts at column 0 on the first cycle after reset deasserts, and the first full debounce takes DEBOUNCE_FRAMES complete frames.
REQ-025 SHALL not clear the synchronizer flops on reset (they carry no state of consequence).

Verification (SCAN_DIV=4, DEBOUNCE_FRAMES=3, frame = 16 cycles)
REQ-026 SHALL check: reset then idle rows=4'hF -> cols sequence 1110,1101,1011,0111 each 4 cycles, key_valid=0, key_code=0, no pulse.
REQ-027 SHALL check: key "2" (r0,c1) held 10 frames -> key_code=2, key_valid=1 at end of 3rd full frame, key_pressed exactly one cycle, no further pulses.
REQ-028 SHALL check: key "8" (r2,c1) pressed for 2 frames then released -> outputs never change, no pulse.
REQ-029 SHALL check: keys "2" and "8" held together 4 frames -> multi_key=1, key_valid=0, key_code=0, no pulse; release "2" -> after 3 frames key_code=8, key_valid=1, one pulse.
REQ-030 SHALL check: "2" stable, then switch directly to "8" -> code changes 2 -> 8 after 3 frames with one pulse; reset asserted mid-frame -> all outputs 0 next cycle, cols=1110.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives one column low at a time, snapshots the
// synchronized rows once per column, and debounces whole-frame classifications.
module keypad_scanner #(
  parameter int SCAN_DIV        = 25000,
  parameter int DEBOUNCE_FRAMES = 8
) (
  input  logic       CLOCK_25,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_pressed,
  output logic       multi_key
);

  localparam int            CW   = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);
  localparam logic [3:0]    DEB  = 4'(DEBOUNCE_FRAMES);

  typedef enum logic [1:0] {KIND_NONE, KIND_SINGLE, KIND_MULTI} kind_e;

  logic [3:0]    rows_meta, rows_sync;
  logic [1:0]    col_idx;
  logic [CW-1:0] period_cnt;
  logic [15:0]   snapshot;
  logic          frame_end;
  kind_e         prev_kind;
  logic [3:0]    prev_code;
  logic [3:0]    stable_cnt;

  kind_e         kind;
  logic [3:0]    code;
  logic [4:0]    hits;
  logic [3:0]    hit_idx;
  logic          same_class;
  logic [3:0]    next_cnt;
  logic          reached;

  // NOTE: synchronizer flops are deliberately left out of reset; they hold no
  // state that matters and flush themselves within two cycles.
  always_ff @(posedge CLOCK_25) begin
    rows_meta <= rows;
    rows_sync <= rows_meta;
  end

  // Snapshot bit index is 4*col + row.
  function automatic logic [3:0] code_of(input logic [3:0] idx);
    case (idx)
      4'd0:  code_of = 4'd1;   4'd1:  code_of = 4'd4;
      4'd2:  code_of = 4'd7;   4'd3:  code_of = 4'd14;
      4'd4:  code_of = 4'd2;   4'd5:  code_of = 4'd5;
      4'd6:  code_of = 4'd8;   4'd7:  code_of = 4'd0;
      4'd8:  code_of = 4'd3;   4'd9:  code_of = 4'd6;
      4'd10: code_of = 4'd9;   4'd11: code_of = 4'd15;
      4'd12: code_of = 4'd10;  4'd13: code_of = 4'd11;
      4'd14: code_of = 4'd12;  default: code_of = 4'd13;
    endcase
  endfunction

  // NOTE: every variable written here gets a default first so no latch is
  // inferred; blocking assignments are correct inside combinational logic.
  always_comb begin
    hits    = '0;
    hit_idx = '0;
    kind    = KIND_NONE;
    code    = '0;
    for (int i = 0; i < 16; i++) begin
      if (snapshot[i]) begin
        hits    = hits + 5'd1;
        hit_idx = 4'(i);
      end
    end
    if (hits == 5'd1) begin
      kind = KIND_SINGLE;
      code = code_of(hit_idx);
    end else if (hits != 5'd0) begin
      kind = KIND_MULTI;
    end
  end

  assign same_class = (kind == prev_kind) && (code == prev_code);
  assign next_cnt   = !same_class        ? 4'd1 :
                      (stable_cnt == DEB) ? DEB  : stable_cnt + 4'd1;
  // Outputs move only on the transition into saturation, never while parked there.
  assign reached    = (next_cnt == DEB) && !(same_class && stable_cnt == DEB);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLOCK_25) begin
    if (reset) begin
      cols        <= 4'b1110;
      col_idx     <= '0;
      period_cnt  <= '0;
      snapshot    <= '0;
      frame_end   <= 1'b0;
      prev_kind   <= KIND_NONE;
      prev_code   <= '0;
      stable_cnt  <= '0;
      key_code    <= '0;
      key_valid   <= 1'b0;
      key_pressed <= 1'b0;
      multi_key   <= 1'b0;
    end else begin
      key_pressed <= 1'b0;
      frame_end   <= (period_cnt == LAST) && (col_idx == 2'd3);

      if (period_cnt == LAST) begin
        period_cnt                   <= '0;
        snapshot[{col_idx, 2'b00} +: 4] <= ~rows_sync;
        col_idx                      <= col_idx + 2'd1;
        cols                         <= ~(4'b0001 << 2'(col_idx + 2'd1));
      end else begin
        period_cnt <= period_cnt + 1'b1;
      end

      if (frame_end) begin
        prev_kind  <= kind;
        prev_code  <= code;
        stable_cnt <= next_cnt;
        if (reached) begin
          key_valid   <= (kind == KIND_SINGLE);
          key_code    <= code;
          multi_key   <= (kind == KIND_MULTI);
          key_pressed <= (kind == KIND_SINGLE) && (!key_valid || key_code != code);
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural keypad matrix model.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_pressed;
  logic       multi_key;

  logic [15:0] keys;  // bit 4*col + row set = key held down
  int          checks = 0;
  int          failures = 0;
  int          pulse_count = 0;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_FRAMES(3)) dut (
    .CLOCK_25   (clk),
    .reset      (reset),
    .rows       (rows),
    .cols       (cols),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .key_pressed(key_pressed),
    .multi_key  (multi_key)
  );

  always #5 clk = ~clk;

  // A pressed key shorts its row to its column; rows are pulled up otherwise.
  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[4*c + r] && !cols[c]) rows[r] = 1'b0;
  end

  always @(negedge clk) if (key_pressed === 1'b1) pulse_count <= pulse_count + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  typedef struct {
    logic [15:0] keys;
    int          frames;
    logic [3:0]  code;
    logic        valid;
    logic        multi;
    int          pulses;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int         p0;
    logic [3:0] exp_cols;

    vecs[0]  = '{16'h0010, 10, 4'd2,  1'b1, 1'b0, 0};  // "2" keeps holding
    vecs[1]  = '{16'h0000, 5,  4'd0,  1'b0, 1'b0, 0};  // release
    vecs[2]  = '{16'h0040, 2,  4'd0,  1'b0, 1'b0, 0};  // "8" glitch, 2 frames
    vecs[3]  = '{16'h0000, 5,  4'd0,  1'b0, 1'b0, 0};
    vecs[4]  = '{16'h0050, 5,  4'd0,  1'b0, 1'b1, 0};  // "2"+"8" together
    vecs[5]  = '{16'h0040, 5,  4'd8,  1'b1, 1'b0, 1};  // release "2"
    vecs[6]  = '{16'h0010, 5,  4'd2,  1'b1, 1'b0, 1};
    vecs[7]  = '{16'h0040, 5,  4'd8,  1'b1, 1'b0, 1};  // direct 2 -> 8
    vecs[8]  = '{16'h0800, 5,  4'd15, 1'b1, 1'b0, 1};
    vecs[9]  = '{16'h0080, 5,  4'd0,  1'b1, 1'b0, 1};  // code 0 is a real key
    vecs[10] = '{16'h0000, 5,  4'd0,  1'b0, 1'b0, 0};
    vecs[11] = '{16'h8000, 5,  4'd13, 1'b1, 1'b0, 1};
    vecs[12] = '{16'h0001, 5,  4'd1,  1'b1, 1'b0, 1};

    reset = 1'b1;
    keys  = '0;
    repeat (4) @(posedge clk);
    #1;
    check("rst_cols", cols, 4'b1110);
    check("rst_valid", key_valid, 1'b0);
    check("rst_code", key_code, 4'd0);
    check("rst_pressed", key_pressed, 1'b0);
    check("rst_multi", multi_key, 1'b0);

    // Idle scan: each column low for four cycles, in order.
    reset = 1'b0;
    for (int n = 0; n < 16; n++) begin
      exp_cols = ~(4'b0001 << (n / 4));
      check($sformatf("idle_cols_c%0d", n), cols, exp_cols);
      @(posedge clk);
      #1;
    end
    repeat (64) @(posedge clk);
    #1;
    check("idle_valid", key_valid, 1'b0);
    check("idle_code", key_code, 4'd0);
    check("idle_pulses", pulse_count, 0);

    // "2" held from reset release: third frame end lands at cycle 48.
    reset = 1'b1;
    keys  = 16'h0010;
    @(posedge clk);
    #1;
    reset = 1'b0;
    p0 = pulse_count;
    repeat (48) @(posedge clk);
    #1;
    check("k2_early_valid", key_valid, 1'b0);
    @(posedge clk);
    #1;
    check("k2_valid", key_valid, 1'b1);
    check("k2_code", key_code, 4'd2);
    check("k2_pressed", key_pressed, 1'b1);
    @(posedge clk);
    #1;
    check("k2_pressed_drop", key_pressed, 1'b0);
    check("k2_pulses", pulse_count - p0, 1);

    for (int i = 0; i < 13; i++) begin
      keys = vecs[i].keys;
      p0   = pulse_count;
      repeat (vecs[i].frames * 16) @(posedge clk);
      #1;
      check($sformatf("v%0d_code", i), key_code, vecs[i].code);
      check($sformatf("v%0d_valid", i), key_valid, vecs[i].valid);
      check($sformatf("v%0d_multi", i), multi_key, vecs[i].multi);
      check($sformatf("v%0d_pulses", i), pulse_count - p0, vecs[i].pulses);
    end

    // Mid-frame reset while "1" is valid, then a full re-debounce.
    repeat (7) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_cols", cols, 4'b1110);
    check("mid_rst_valid", key_valid, 1'b0);
    check("mid_rst_code", key_code, 4'd0);
    check("mid_rst_multi", multi_key, 1'b0);
    check("mid_rst_pressed", key_pressed, 1'b0);
    reset = 1'b0;
    repeat (48) @(posedge clk);
    #1;
    check("post_rst_early_valid", key_valid, 1'b0);
    @(posedge clk);
    #1;
    check("post_rst_valid", key_valid, 1'b1);
    check("post_rst_code", key_code, 4'd1);
    check("post_rst_pressed", key_pressed, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
